// File: rtl/snake_pkg.sv
// snake_pkg: shared heading, move and FSM state encodings for the snake move executor.
package snake_pkg;
    localparam logic [1:0] HDG_UP = 2'd0, HDG_RIGHT = 2'd1, HDG_DOWN = 2'd2, HDG_LEFT = 2'd3;
    localparam logic [1:0] MV_KEEP = 2'd0, MV_LEFT = 2'd1, MV_RIGHT = 2'd2;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: game-tick divider; tc is high during the last cycle of each TICK_DIV-cycle tick.
module snake_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tc = en && cnt_q == LAST;
        cnt_d = clear ? '0 : en ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/snake_move_executor.sv
// snake_move_executor: applies the steering decision once per game tick, moves the head
// and detects wall collisions.
module snake_move_executor
    import snake_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int TICK_DIV = 1000000,
    parameter int START_X = 8,
    parameter int START_Y = 8,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    move,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    heading,
    output logic          step,
    output logic          alive,
    output logic          game_over,
    output logic [15:0]   step_count
);
    localparam logic [XW-1:0] SX = XW'(START_X);
    localparam logic [YW-1:0] SY = YW'(START_Y);
    localparam logic [XW:0] GW = (XW + 1)'(GRID_W);
    localparam logic [YW:0] GH = (YW + 1)'(GRID_H);
    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    hdg_q, hdg_d, nh;
    logic          step_q, step_d, tc, hit;
    logic [15:0]   cnt_q, cnt_d;
    logic [XW:0]   dx, nx;
    logic [YW:0]   dy, ny;
    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q != ST_RUN),
        .en   (state_q == ST_RUN),
        .tc   (tc)
    );
    // One extra bit on x/y lets a step off the low edge show up as a large value instead of wrapping.
    always_comb begin
        nh = move == MV_LEFT ? hdg_q - 2'd1 : move == MV_RIGHT ? hdg_q + 2'd1 : hdg_q;
        dx = nh == HDG_RIGHT ? (XW + 1)'(1) : nh == HDG_LEFT ? '1 : '0;
        dy = nh == HDG_DOWN ? (YW + 1)'(1) : nh == HDG_UP ? '1 : '0;
        nx = {1'b0, x_q} + dx;
        ny = {1'b0, y_q} + dy;
        hit = nx >= GW || ny >= GH;
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        hdg_d = hdg_q;
        cnt_d = cnt_q;
        step_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (tc) begin
                hdg_d = nh;
                if (hit) begin
                    state_d = ST_DEAD;
                end else begin
                    x_d = nx[XW-1:0];
                    y_d = ny[YW-1:0];
                    step_d = 1'b1;
                    cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
                end
            end
        end else if (start) begin
            state_d = ST_RUN;
            x_d = SX;
            y_d = SY;
            hdg_d = HDG_UP;
            cnt_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q <= SX;
            y_q <= SY;
            hdg_q <= HDG_UP;
            step_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            hdg_q <= hdg_d;
            step_q <= step_d;
            cnt_q <= cnt_d;
        end
    end
    assign head_x = x_q;
    assign head_y = y_q;
    assign heading = hdg_q;
    assign step = step_q;
    assign step_count = cnt_q;
    assign alive = state_q == ST_RUN;
    assign game_over = state_q == ST_DEAD;
endmodule

// File: tb/tb_snake_move_executor.sv
// tb_snake_move_executor: directed table of per-tick moves with hand-computed head positions,
// plus sequences for death, restart, async reset and step_count saturation.
module tb_snake_move_executor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  move = 2'd0;
    logic [3:0]  head_x, head_y;
    logic [1:0]  heading;
    logic        step, alive, game_over;
    logic [15:0] step_count;
    int checks = 0;
    int failures = 0;

    snake_move_executor #(
        .GRID_W(16), .GRID_H(16), .TICK_DIV(4), .START_X(8), .START_Y(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move(move),
        .head_x(head_x), .head_y(head_y), .heading(heading), .step(step),
        .alive(alive), .game_over(game_over), .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rs;
        logic [1:0] mv;
        int         x, y, h, c;
    } vec_t;
    vec_t v[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input int x, input int y, input int h, input int c,
                             input logic st, input logic al, input logic go);
        check({nm, ".head_x"}, 32'(head_x), 32'(x));
        check({nm, ".head_y"}, 32'(head_y), 32'(y));
        check({nm, ".heading"}, 32'(heading), 32'(h));
        check({nm, ".step_count"}, 32'(step_count), 32'(c));
        check({nm, ".step"}, 32'(step), 32'(st));
        check({nm, ".alive"}, 32'(alive), 32'(al));
        check({nm, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    task automatic tick(input logic [1:0] mv);
        move = mv;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("step_between_ticks", 32'(step), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_start();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        v[0]  = '{1'b1, 2'd0, 8, 7, 0, 1};
        v[1]  = '{1'b0, 2'd0, 8, 6, 0, 2};
        v[2]  = '{1'b0, 2'd0, 8, 5, 0, 3};
        v[3]  = '{1'b1, 2'd2, 9, 8, 1, 1};
        v[4]  = '{1'b0, 2'd2, 9, 9, 2, 2};
        v[5]  = '{1'b0, 2'd1, 10, 9, 1, 3};
        v[6]  = '{1'b1, 2'd1, 7, 8, 3, 1};
        for (int i = 0; i < 7; i++) v[7 + i] = '{1'b0, (i % 2 == 0) ? 2'd0 : 2'd3, 6 - i, 8, 3, 2 + i};

        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 8, 8, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_step", 32'(step), 32'd0);
            check("idle_alive", 32'(alive), 32'd0);
        end
        check_all("idle_hold", 8, 8, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            if (v[i].rs) reset_start();
            tick(v[i].mv);
            check_all($sformatf("vec%0d", i), v[i].x, v[i].y, v[i].h, v[i].c, 1'b1, 1'b1, 1'b0);
        end

        tick(2'd0);
        check_all("wall_hit", 0, 8, 3, 8, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("dead_step", 32'(step), 32'd0);
        end
        check_all("dead_hold", 0, 8, 3, 8, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_all("restart", 8, 8, 0, 0, 1'b0, 1'b1, 1'b0);
        tick(2'd0);
        check_all("restart_tick1", 8, 7, 0, 1, 1'b1, 1'b1, 1'b0);
        tick(2'd0);
        check_all("start_held_tick2", 8, 6, 0, 2, 1'b1, 1'b1, 1'b0);
        start = 1'b0;

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 8, 8, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_all("after_reset_start", 8, 8, 0, 0, 1'b0, 1'b1, 1'b0);
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        tick(2'd0);
        check_all("sat1", 8, 7, 0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        tick(2'd0);
        check_all("sat2", 8, 6, 0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        tick(2'd0);
        check_all("sat3", 8, 5, 0, 16'hFFFF, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
